// File: rtl/sram_bridge_pkg.sv
// ============================================================================
// Module  : sram_bridge_pkg
// Purpose : Shared types and constants for sram_word_bridge: FSM states,
//           request opcode, half-word select constants, phase counter width
//           and the SRAM strobe bundle with its per-phase encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   localparam logic HALF_LO     = 1'b0;
   localparam logic HALF_HI     = 1'b1;
   localparam int   PHASE_CNT_W = 4;

   // Registered SRAM control bundle; dq_oe enables the bridge's DQ driver.
   typedef struct packed {
      logic ce_n;
      logic we_n;
      logic oe_n;
      logic lb_n;
      logic ub_n;
      logic dq_oe;
   } pins_t;

   localparam pins_t PINS_IDLE = '{ce_n: 1'b1, we_n: 1'b1, oe_n: 1'b1,
                                   lb_n: 1'b1, ub_n: 1'b1, dq_oe: 1'b0};

   // Strobes for one half-word phase; mask is the two byte enables of the half.
   function automatic pins_t phase_pins(input op_e op, input logic [1:0] mask);
      pins_t p;
      p = PINS_IDLE;
      p.ce_n = 1'b0;
      if (op == OP_WR) begin
         p.we_n  = 1'b0;
         p.oe_n  = 1'b1;
         p.lb_n  = ~mask[0];
         p.ub_n  = ~mask[1];
         p.dq_oe = 1'b1;
      end else begin
         p.we_n  = 1'b1;
         p.oe_n  = 1'b0;
         p.lb_n  = 1'b0;
         p.ub_n  = 1'b0;
         p.dq_oe = 1'b0;
      end
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_word_bridge.sv
// ============================================================================
// Module  : sram_word_bridge
// Purpose : Performs one 32-bit LSU load/store as two 16-bit phases on an
//           IS61WV25616 asynchronous SRAM, with byte-lane masking and read
//           half-word assembly. Pulses o_ACK for one cycle on completion.
// Ports   : i_clk, i_reset           - clock, synchronous active-high reset
//           i_ADDR/i_WDATA/i_BMASK   - byte address, store data, byte enables
//           i_WREN/i_RDEN            - request strobes (write wins on tie)
//           o_RDATA/o_ACK            - assembled read word, completion pulse
//           SRAM_ADDR/SRAM_DQ        - half-word address, bidirectional data
//           SRAM_*_N                 - active-low SRAM strobes (registered)
// Config  : define SRAM_SKIP_HALF_EN to skip write phases whose two byte
//           enables are both clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_word_bridge
   import sram_bridge_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 18
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_ADDR,
   input  logic [31:0]       i_WDATA,
   input  logic [3:0]        i_BMASK,
   input  logic              i_WREN,
   input  logic              i_RDEN,
   output logic [31:0]       o_RDATA,
   output logic              o_ACK,
   output logic [17:0]       SRAM_ADDR,
   inout  wire  [15:0]       SRAM_DQ,
   output logic              SRAM_CE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_LB_N,
   output logic              SRAM_UB_N
);

   localparam logic [PHASE_CNT_W-1:0] c_CNT_LOAD = PHASE_CNT_W'(WAIT_CYCLES - 1);

   state_e                 state_q;
   op_e                    op_q;
   logic [15:0]            word_q;        // word index = byte address [17:2]
   logic [15:0]            wdata_hi_q;    // only the HI half is needed after accept
   logic [1:0]             bmask_hi_q;
   logic [PHASE_CNT_W-1:0] cnt_q;
   logic                   ack_q;
   logic [31:0]            rdata_q;
   logic [17:0]            addr_q;
   pins_t                  pins_q;
   logic [15:0]            dq_out_q;

   logic                   w_req;
   op_e                    w_op;
   logic [15:0]            w_word;
   logic                   w_unused_addr;

   assign w_req         = i_WREN | i_RDEN;
   assign w_op          = i_WREN ? OP_WR : OP_RD;
   assign w_word        = i_ADDR[17:2];
   assign w_unused_addr = ^i_ADDR[1:0];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         op_q       <= OP_RD;
         word_q     <= '0;
         wdata_hi_q <= '0;
         bmask_hi_q <= '0;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
         addr_q     <= '0;
         pins_q     <= PINS_IDLE;
         dq_out_q   <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (w_req) begin
                  op_q       <= w_op;
                  word_q     <= w_word;
                  wdata_hi_q <= i_WDATA[31:16];
                  bmask_hi_q <= i_BMASK[3:2];
                  cnt_q      <= c_CNT_LOAD;
`ifdef SRAM_SKIP_HALF_EN
                  if (i_WREN && (i_BMASK[1:0] == 2'b00)) begin
                     if (i_BMASK[3:2] == 2'b00) begin
                        // Nothing to write at all: acknowledge immediately.
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                     end else begin
                        state_q  <= HI;
                        addr_q   <= {1'b0, w_word, HALF_HI};
                        pins_q   <= phase_pins(OP_WR, i_BMASK[3:2]);
                        dq_out_q <= i_WDATA[31:16];
                     end
                  end else begin
                     state_q  <= LO;
                     addr_q   <= {1'b0, w_word, HALF_LO};
                     pins_q   <= phase_pins(w_op, i_BMASK[1:0]);
                     dq_out_q <= i_WDATA[15:0];
                  end
`else
                  state_q  <= LO;
                  addr_q   <= {1'b0, w_word, HALF_LO};
                  pins_q   <= phase_pins(w_op, i_BMASK[1:0]);
                  dq_out_q <= i_WDATA[15:0];
`endif
               end
            end

            LO: begin
               if (cnt_q == '0) begin
                  if (op_q == OP_RD) begin
                     rdata_q[15:0] <= SRAM_DQ;
                  end
`ifdef SRAM_SKIP_HALF_EN
                  if ((op_q == OP_WR) && (bmask_hi_q == 2'b00)) begin
                     state_q <= DONE;
                     ack_q   <= 1'b1;
                     addr_q  <= '0;
                     pins_q  <= PINS_IDLE;
                  end else begin
                     state_q  <= HI;
                     cnt_q    <= c_CNT_LOAD;
                     addr_q   <= {1'b0, word_q, HALF_HI};
                     pins_q   <= phase_pins(op_q, bmask_hi_q);
                     dq_out_q <= wdata_hi_q;
                  end
`else
                  state_q  <= HI;
                  cnt_q    <= c_CNT_LOAD;
                  addr_q   <= {1'b0, word_q, HALF_HI};
                  pins_q   <= phase_pins(op_q, bmask_hi_q);
                  dq_out_q <= wdata_hi_q;
`endif
               end else begin
                  cnt_q <= cnt_q - PHASE_CNT_W'(1);
               end
            end

            HI: begin
               if (cnt_q == '0) begin
                  if (op_q == OP_RD) begin
                     rdata_q[31:16] <= SRAM_DQ;
                  end
                  state_q <= DONE;
                  ack_q   <= 1'b1;
                  addr_q  <= '0;
                  pins_q  <= PINS_IDLE;
               end else begin
                  cnt_q <= cnt_q - PHASE_CNT_W'(1);
               end
            end

            DONE: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
               addr_q  <= '0;
               pins_q  <= PINS_IDLE;
            end
         endcase
      end
   end

   // Driver enable is registered with the strobes, so it never asserts in a read phase.
   assign SRAM_DQ   = pins_q.dq_oe ? dq_out_q : 16'hzzzz;

   assign SRAM_ADDR = addr_q;
   assign SRAM_CE_N = pins_q.ce_n;
   assign SRAM_WE_N = pins_q.we_n;
   assign SRAM_OE_N = pins_q.oe_n;
   assign SRAM_LB_N = pins_q.lb_n;
   assign SRAM_UB_N = pins_q.ub_n;
   assign o_ACK     = ack_q;
   assign o_RDATA   = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_word_bridge.sv
// ============================================================================
// Module  : tb_sram_word_bridge
// Purpose : Directed self-checking bench for sram_word_bridge with a simple
//           behavioural 256K x 16 SRAM on the pins. Expected values are
//           hand-computed for WAIT_CYCLES = 2.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_word_bridge;

   logic        clk;
   logic        rst;
   logic [17:0] i_ADDR;
   logic [31:0] i_WDATA;
   logic [3:0]  i_BMASK;
   logic        i_WREN;
   logic        i_RDEN;
   logic [31:0] o_RDATA;
   logic        o_ACK;
   logic [17:0] SRAM_ADDR;
   wire  [15:0] SRAM_DQ;
   logic        SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N;

   int n_checks = 0;
   int n_errors = 0;

   sram_word_bridge #(.WAIT_CYCLES(2), .ADDR_W(18)) u_dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_ADDR    (i_ADDR),
      .i_WDATA   (i_WDATA),
      .i_BMASK   (i_BMASK),
      .i_WREN    (i_WREN),
      .i_RDEN    (i_RDEN),
      .o_RDATA   (o_RDATA),
      .o_ACK     (o_ACK),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DQ   (SRAM_DQ),
      .SRAM_CE_N (SRAM_CE_N),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_OE_N (SRAM_OE_N),
      .SRAM_LB_N (SRAM_LB_N),
      .SRAM_UB_N (SRAM_UB_N)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAM: combinational read, byte-masked write on each clock.
   logic [15:0] mem [0:262143];
   logic        w_sram_rd;
   assign w_sram_rd = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
   assign SRAM_DQ   = w_sram_rd ? mem[SRAM_ADDR] : 16'hzzzz;

   always @(posedge clk) begin
      if (!SRAM_CE_N && !SRAM_WE_N) begin
         if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  <= SRAM_DQ[7:0];
         if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
      end
   end

   // Per-cycle trace of the last transaction; index = cycles after accept.
   logic [17:0] t_addr [0:15];
   logic [15:0] t_dq   [0:15];
   logic [4:0]  t_pins [0:15];   // {CE_N, WE_N, OE_N, LB_N, UB_N}
   int          ack_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] pins_now();
      return {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N};
   endfunction

   // Issue one request from IDLE, trace until o_ACK, return positioned in IDLE.
   task automatic do_op(input logic wr, input logic rd, input logic [17:0] addr,
                        input logic [31:0] data, input logic [3:0] mask);
      i_WREN  = wr;
      i_RDEN  = rd;
      i_ADDR  = addr;
      i_WDATA = data;
      i_BMASK = mask;
      @(posedge clk); #1;
      i_WREN  = 1'b0;
      i_RDEN  = 1'b0;
      ack_cyc = 0;
      for (int c = 1; c < 16; c++) begin
         t_addr[c] = SRAM_ADDR;
         t_dq[c]   = SRAM_DQ;
         t_pins[c] = pins_now();
         if (o_ACK) begin
            ack_cyc = c;
            break;
         end
         @(posedge clk); #1;
      end
      if (ack_cyc == 0) chk("ack_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int ack_seen;
      logic [4:0] oe_acc;
      rst = 1'b1; i_ADDR = '0; i_WDATA = '0; i_BMASK = '0; i_WREN = 1'b0; i_RDEN = 1'b0;

      // Reset while idle
      repeat (2) @(posedge clk);
      #1;
      chk("rst_strobes", {27'd0, pins_now()}, 32'h1F);
      chk("rst_ack",     {31'd0, o_ACK},      32'd0);
      chk("rst_rdata",   o_RDATA,             32'd0);
      chk("rst_addr",    {14'd0, SRAM_ADDR},  32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Full write 0xDEADBEEF to 0x104
      do_op(1'b1, 1'b0, 18'h00104, 32'hDEADBEEF, 4'hF);
      chk("wr_ack_cyc", ack_cyc,              32'd5);
      chk("wr_c1_addr", {14'd0, t_addr[1]},   32'h82);
      chk("wr_c1_dq",   {16'd0, t_dq[1]},     32'hBEEF);
      chk("wr_c1_pins", {27'd0, t_pins[1]},   32'h04);
      chk("wr_c2_pins", {27'd0, t_pins[2]},   32'h04);
      chk("wr_c3_addr", {14'd0, t_addr[3]},   32'h83);
      chk("wr_c3_dq",   {16'd0, t_dq[3]},     32'hDEAD);
      chk("wr_c4_pins", {27'd0, t_pins[4]},   32'h04);
      chk("wr_done_pins", {27'd0, t_pins[5]}, 32'h1F);
      chk("wr_done_addr", {14'd0, t_addr[5]}, 32'd0);

      // Read it back
      do_op(1'b0, 1'b1, 18'h00104, 32'd0, 4'h0);
      chk("rd_ack_cyc", ack_cyc,            32'd5);
      chk("rd_c1_pins", {27'd0, t_pins[1]}, 32'h08);
      chk("rd_rdata",   o_RDATA,            32'hDEADBEEF);

      // Byte write to lane 0
      do_op(1'b1, 1'b0, 18'h00104, 32'h000000AA, 4'b0001);
      chk("bw_c1_pins", {27'd0, t_pins[1]}, 32'h05);
      chk("bw_c3_pins", {27'd0, t_pins[3]}, 32'h07);
      chk("bw_ack_cyc", ack_cyc,            32'd5);
      do_op(1'b0, 1'b1, 18'h00104, 32'd0, 4'h0);
      chk("bw_rdata",   o_RDATA,            32'hDEADBEAA);

      // Simultaneous write+read: write wins; o_RDATA holds
      do_op(1'b1, 1'b1, 18'h00200, 32'h12345678, 4'hF);
      oe_acc = 5'd0;
      for (int c = 1; c <= 4; c++) oe_acc[c] = t_pins[c][2];
      chk("wrrd_oe_high", {27'd0, oe_acc},   32'h1E);
      chk("wrrd_c1_we",   {31'd0, t_pins[1][3]}, 32'd0);
      chk("wrrd_rdata_hold", o_RDATA,        32'hDEADBEAA);
      do_op(1'b0, 1'b1, 18'h00200, 32'd0, 4'h0);
      chk("wrrd_readback", o_RDATA,          32'h12345678);

      // Reset in the first HI cycle of a write
      i_WREN = 1'b1; i_ADDR = 18'h00300; i_WDATA = 32'hCAFEF00D; i_BMASK = 4'hF;
      @(posedge clk); #1;
      i_WREN = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_hi_addr", {14'd0, SRAM_ADDR}, 32'h181);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_strobes", {27'd0, pins_now()}, 32'h1F);
      chk("mid_rst_addr",    {14'd0, SRAM_ADDR},  32'd0);
      rst = 1'b0;
      ack_seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (o_ACK) ack_seen = 1;
         @(posedge clk); #1;
      end
      chk("mid_rst_no_ack", ack_seen, 32'd0);
      do_op(1'b0, 1'b1, 18'h00300, 32'd0, 4'h0);
      chk("mid_rd_ack_cyc", ack_cyc,                32'd5);
      chk("mid_rd_lo",      {16'd0, o_RDATA[15:0]}, 32'hF00D);

      // Empty mask write and upper-half-only write
      do_op(1'b1, 1'b0, 18'h00400, 32'h55555555, 4'b0000);
`ifdef SRAM_SKIP_HALF_EN
      chk("m0_ack_cyc", ack_cyc, 32'd1);
`else
      chk("m0_ack_cyc", ack_cyc,            32'd5);
      chk("m0_c1_pins", {27'd0, t_pins[1]}, 32'h07);
      chk("m0_c3_pins", {27'd0, t_pins[3]}, 32'h07);
`endif
      do_op(1'b1, 1'b0, 18'h00500, 32'h11223344, 4'b1100);
`ifdef SRAM_SKIP_HALF_EN
      chk("mhi_ack_cyc", ack_cyc,             32'd3);
      chk("mhi_c1_addr", {14'd0, t_addr[1]},  32'h281);
      chk("mhi_c1_pins", {27'd0, t_pins[1]},  32'h04);
      chk("mhi_c1_dq",   {16'd0, t_dq[1]},    32'h1122);
`else
      chk("mhi_ack_cyc", ack_cyc,             32'd5);
      chk("mhi_c1_addr", {14'd0, t_addr[1]},  32'h280);
      chk("mhi_c1_pins", {27'd0, t_pins[1]},  32'h07);
      chk("mhi_c3_addr", {14'd0, t_addr[3]},  32'h281);
      chk("mhi_c3_pins", {27'd0, t_pins[3]},  32'h04);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sram_word_bridge.md
Name: sram_word_bridge

Overview:
Downstream neighbour of the LSU data-memory path. It takes one 32-bit load/store request per handshake and performs it as two 16-bit phases on the external IS61WV25616 asynchronous SRAM (256K x 16). Byte lanes are masked, and read halves are assembled into a 32-bit word. It produces a one-cycle o_ACK that the LSU uses to release its stall.

Parameters:
WAIT_CYCLES, 2, cycles each half-word phase is held on the SRAM pins (1..15)
ADDR_W, 18, byte-address width of i_ADDR

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_ADDR  in  ADDR_W  byte address; [1:0] ignored, word index = i_ADDR[17:2]
i_WDATA  in  32  store data, little-endian byte lanes
i_BMASK  in  4  byte enables, bit n = byte n
i_WREN  in  1  write request
i_RDEN  in  1  read request
o_RDATA  out  32  assembled read word
o_ACK  out  1  one-cycle completion pulse
SRAM_ADDR  out  18  SRAM half-word address
SRAM_DQ  inout  16  SRAM data bus
SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  active-low SRAM strobes

Behaviour:
- The clock is i_clk. Reset is i_reset, which is synchronous and active-high.
- States: IDLE, LO, HI, DONE.
- In IDLE, a request is accepted when i_WREN or i_RDEN is 1. If both are 1, the write wins.
- On accept, latch addr, wdata, bmask and the op. Inputs are ignored until the next IDLE.
- LO phase, WAIT_CYCLES cycles: SRAM_ADDR = {1'b0, word_idx, 1'b0}.
- HI phase, WAIT_CYCLES cycles: SRAM_ADDR = {1'b0, word_idx, 1'b1}.
- Phase length is counted by a 4-bit down-counter loaded with WAIT_CYCLES-1 on phase entry. The phase exits when the counter reaches 0.
- DONE lasts 1 cycle: o_ACK = 1, then return to IDLE.
- Latency: accept edge at cycle 0, LO covers cycles 1..W, HI covers W+1..2W, o_ACK is high in cycle 2W+1. With W=2, o_ACK is high in cycle 5.
- Back-to-back requests: a request still held in the cycle after DONE starts a new transaction. There is no de-duplication, and the LSU is responsible for dropping the request.
- All SRAM pin outputs are registered and change only on state or phase entry.
- Write phase pins: CE_N=0, OE_N=1, WE_N=0 for the whole phase, and DQ is driven.
  - LO phase: DQ = wdata[15:0], LB_N = ~bmask[0], UB_N = ~bmask[1].
  - HI phase: DQ = wdata[31:16], LB_N = ~bmask[2], UB_N = ~bmask[3].
- Read phase pins: CE_N=0, OE_N=0, WE_N=1, LB_N=UB_N=0, DQ = 'z.
  - SRAM_DQ is sampled on the last cycle of LO into o_RDATA[15:0], and on the last cycle of HI into o_RDATA[31:16].
- o_RDATA updates only on reads and holds its value through writes and IDLE.
- IDLE and DONE pins: CE_N=WE_N=OE_N=LB_N=UB_N=1, SRAM_ADDR=0, DQ='z.
- The SRAM_DQ driver is enabled only in write phases. DQ is never driven in the cycle a read phase begins.
- Reset values: state=IDLE, o_ACK=0, o_RDATA=0, all strobes 1, SRAM_ADDR=0, DQ='z.
- Reset mid-transaction: return to IDLE on the reset edge with no o_ACK. A partially written word is left as written.
- A write with bmask=4'b0000 still runs both phases with LB_N=UB_N=1 and is acknowledged.

Optional Feature:
SRAM_SKIP_HALF_EN
- Defined: on writes, a phase whose two mask bits are both 0 is skipped.
  - bmask=4'b0011 goes LO->DONE, and o_ACK arrives at cycle W+1.
  - bmask=4'b1100 goes IDLE->HI.
  - bmask=0 goes IDLE->DONE, with o_ACK at cycle 1.
  - Reads always run both phases.
- Undefined: both phases always run, as described in Behaviour.

Decomposition:
- Package sram_bridge_pkg holds:
  - the state enum (IDLE, LO, HI, DONE);
  - the op enum (OP_RD, OP_WR);
  - constants HALF_LO=1'b0 and HALF_HI=1'b1;
  - the phase counter width of 4.
- No sub-module. The phase counter and the tri-state driver stay inline; the expected RTL is about 200 lines.

Test Plan:
- Reset while idle: hold i_reset=1 for 2 cycles. Required: all strobes 1, o_ACK=0, o_RDATA=0, DQ='z.
- Full write then read, W=2:
  - Write i_ADDR=0x00104, i_WDATA=0xDEADBEEF, mask=4'hF. Required: SRAM_ADDR=0x00082 with DQ=0xBEEF, then 0x00083 with DQ=0xDEAD; WE_N low for 2 cycles each; o_ACK at cycle 5.
  - Read i_ADDR=0x00104. Required: o_RDATA=0xDEADBEEF with o_ACK at cycle 5.
- Byte write: write 0x000000AA with mask=4'b0001 to 0x00104. Required: LO phase LB_N=0, UB_N=1; HI phase LB_N=UB_N=1; a subsequent read returns 0xDEADBEAA.
- Simultaneous i_WREN=i_RDEN=1: required write cycle, OE_N=1 throughout.
- Reset mid-operation: assert i_reset in HI cycle 1 of a write. Required: strobes 1 on the next edge, no o_ACK pulse, and the next request is served from IDLE normally.
- With SRAM_SKIP_HALF_EN defined: write with mask=4'b1100. Required: no LO phase, SRAM_ADDR goes directly to the odd half-word address, o_ACK at cycle W+1=3.
